horizontal_blur: RTL and testbench
==================================

HORIZONTAL_BLUR -- requirements
Module: horizontal_blur

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  pixel clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_vid_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]} from the upstream stage.
REQ-005 i_vid_hsync / i_vid_vsync / i_vid_VDE  in  1 each  timing from upstream; VDE high = active pixel.
REQ-006 sw  in  4  mode select; blur requested when sw == MODE_BLUR (4'd3).
REQ-007 o_vid_data  out  24  registered pixel to the next colour stage.
REQ-008 o_vid_hsync / o_vid_vsync / o_vid_VDE  out  1 each  input timing delayed to match data.

Function
REQ-009 All outputs SHALL have a fixed latency of exactly 2 clk cycles in every mode; sync, VDE and data stay aligned.
REQ-010 Pipeline SHALL hold d1 = input delayed 1 cycle and d2 = input delayed 2 cycles (data + VDE).
REQ-011 Blur output per channel SHALL be (L + 2*C + R) >> 2, with C = d1, L = d2, R = current input, computed in 10 bits and truncated to 8 (no rounding, no saturation needed).
REQ-012 Left edge: when d1 VDE = 1 and d2 VDE = 0, L SHALL equal C.
REQ-013 Right edge: when d1 VDE = 1 and input VDE = 0, R SHALL equal C.
REQ-014 Single-pixel line (both edges at once): output SHALL equal C unchanged.
REQ-015 Passthrough mode: o_vid_data SHALL equal d1 data registered (2-cycle delayed input, unmodified).
REQ-016 Mode FSM states: PASS, BLUR; transitions SHALL occur only on a rising edge of i_vid_vsync, to BLUR if sw == 4'd3, else to PASS.
REQ-017 sw changes mid-frame SHALL NOT affect output until the next vsync rising edge.
REQ-018 vsync rising edge coincident with sw change: the sw value sampled in that same cycle SHALL decide the new state.
REQ-019 Blanking (d1 VDE = 0): o_vid_data SHALL be d1 data unmodified in both modes (unless REQ-023 applies).

Reset
REQ-020 On rst: o_vid_data = 24'h0, o_vid_hsync = o_vid_vsync = o_vid_VDE = 0, d1/d2 data and VDE = 0, FSM = PASS, vsync edge detector history = 0.
REQ-021 Reset asserted mid-line SHALL clear the pipeline immediately; first pixel after release SHALL be treated as a left edge.
REQ-022 Output after reset release SHALL be passthrough until the first vsync rising edge with sw == 4'd3.

Configuration
REQ-023 Macro HBLUR_BLANK_ZERO_EN: when defined, o_vid_data SHALL be 24'h0 whenever o_vid_VDE is 0 (both modes); when undefined, REQ-019 holds.

Structure
REQ-024 Shared video package SHALL hold MODE_BLUR = 4'd3, PIX_W = 24, CH_W = 8 and the mode-state type {PASS, BLUR}.
REQ-025 One sub-module blur3_channel SHALL compute REQ-011 for a single 8-bit channel; instantiated 3 times.

Verification
REQ-026 sw=3, vsync pulse, then line R=G=B = 10,20,30 (VDE high 3 cycles) -> outputs 2 cycles later: 12, 20, 27 per channel.
REQ-027 sw=0, same line -> outputs 10,20,30 delayed 2 cycles; hsync/vsync/VDE delayed 2 cycles exactly.
REQ-028 Single-pixel line value 8'hC8 in BLUR -> output 8'hC8.
REQ-029 In BLUR, set sw=0 mid-frame -> blur continues to frame end; passthrough from next vsync rising edge.
REQ-030 Assert rst mid-line -> all outputs 0 in same cycle; next line first pixel handled as left edge.
REQ-031 With HBLUR_BLANK_ZERO_EN, input data 24'hFFFFFF during VDE=0 -> o_vid_data 24'h0; without macro -> 24'hFFFFFF.

Source files
------------

// File: rtl/horizontal_blur_pkg.sv
// Shared video constants and mode-state type for the horizontal blur stage.
// Optional build macro: HBLUR_BLANK_ZERO_EN (zero output data during blanking).
package horizontal_blur_pkg;
    localparam int         PIX_W     = 24;
    localparam int         CH_W      = 8;
    localparam logic [3:0] MODE_BLUR = 4'd3;

    typedef enum logic {
        PASS = 1'b0,
        BLUR = 1'b1
    } mode_e;
endpackage

// File: rtl/horizontal_blur_if.sv
// Video bundle between upstream stage, blur stage and next colour stage.
// Upstream drives i_* and reads o_*; the blur stage does the opposite.
interface horizontal_blur_if;
    import horizontal_blur_pkg::*;

    logic [PIX_W-1:0] i_vid_data;
    logic             i_vid_hsync;
    logic             i_vid_vsync;
    logic             i_vid_VDE;
    logic [PIX_W-1:0] o_vid_data;
    logic             o_vid_hsync;
    logic             o_vid_vsync;
    logic             o_vid_VDE;

    modport master (
        output i_vid_data, i_vid_hsync, i_vid_vsync, i_vid_VDE,
        input  o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE
    );

    modport slave (
        input  i_vid_data, i_vid_hsync, i_vid_vsync, i_vid_VDE,
        output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE
    );
endinterface

// File: rtl/horizontal_blur_blur3_channel.sv
// One-channel [1 2 1]/4 horizontal kernel; missing neighbours at line edges
// are replaced by the centre pixel.
import horizontal_blur_pkg::*;

module blur3_channel (
    input  logic [CH_W-1:0] i_l,
    input  logic [CH_W-1:0] i_c,
    input  logic [CH_W-1:0] i_r,
    input  logic            i_l_vld,
    input  logic            i_r_vld,
    output logic [CH_W-1:0] o_pix
);
    logic [CH_W-1:0] w_l;
    logic [CH_W-1:0] w_r;
    logic [CH_W+1:0] w_sum;

    assign w_l   = i_l_vld ? i_l : i_c;
    assign w_r   = i_r_vld ? i_r : i_c;
    assign w_sum = {2'b00, w_l} + {1'b0, i_c, 1'b0} + {2'b00, w_r};
    assign o_pix = w_sum[CH_W+1:2];
endmodule

// File: rtl/horizontal_blur.sv
// Horizontal 3-tap blur stage, fixed 2-cycle latency; mode latched on vsync rise.
// Optional build macro: HBLUR_BLANK_ZERO_EN (zero output data during blanking).
import horizontal_blur_pkg::*;

module horizontal_blur (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    horizontal_blur_if.slave vid
);
    logic [PIX_W-1:0] r_d1_data;
    logic [PIX_W-1:0] r_d2_data;
    logic             r_d1_vde;
    logic             r_d2_vde;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_vs_prev;
    mode_e            r_state;
    logic [PIX_W-1:0] r_out_data;
    logic             r_out_hs;
    logic             r_out_vs;
    logic             r_out_vde;

    logic [PIX_W-1:0] w_blur;
    logic [PIX_W-1:0] w_next_data;
    logic             w_vs_rise;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        blur3_channel u_ch (
            .i_l     (r_d2_data[g*CH_W +: CH_W]),
            .i_c     (r_d1_data[g*CH_W +: CH_W]),
            .i_r     (vid.i_vid_data[g*CH_W +: CH_W]),
            .i_l_vld (r_d2_vde),
            .i_r_vld (vid.i_vid_VDE),
            .o_pix   (w_blur[g*CH_W +: CH_W])
        );
    end

    assign w_vs_rise = vid.i_vid_vsync & ~r_vs_prev;

    always_comb begin
        w_next_data = r_d1_data;
        if (r_d1_vde && r_state == BLUR)
            w_next_data = w_blur;
`ifdef HBLUR_BLANK_ZERO_EN
        if (!r_d1_vde)
            w_next_data = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1_data  <= '0;
            r_d2_data  <= '0;
            r_d1_vde   <= 1'b0;
            r_d2_vde   <= 1'b0;
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_state    <= PASS;
            r_out_data <= '0;
            r_out_hs   <= 1'b0;
            r_out_vs   <= 1'b0;
            r_out_vde  <= 1'b0;
        end else begin
            r_d1_data  <= vid.i_vid_data;
            r_d2_data  <= r_d1_data;
            r_d1_vde   <= vid.i_vid_VDE;
            r_d2_vde   <= r_d1_vde;
            r_hs1      <= vid.i_vid_hsync;
            r_vs1      <= vid.i_vid_vsync;
            r_vs_prev  <= vid.i_vid_vsync;
            r_out_data <= w_next_data;
            r_out_hs   <= r_hs1;
            r_out_vs   <= r_vs1;
            r_out_vde  <= r_d1_vde;
            // Mode only changes at frame start so a frame is never mixed
            if (w_vs_rise)
                r_state <= (sw == MODE_BLUR) ? BLUR : PASS;
        end
    end

    assign vid.o_vid_data  = r_out_data;
    assign vid.o_vid_hsync = r_out_hs;
    assign vid.o_vid_vsync = r_out_vs;
    assign vid.o_vid_VDE   = r_out_vde;
endmodule

// File: tb/tb_horizontal_blur.sv
// Table-driven bench for horizontal_blur with a 2-deep expected-output queue.
module tb_horizontal_blur;
    typedef struct {
        logic [3:0]  sw;
        logic        vs;
        logic        hs;
        logic        vde;
        logic [23:0] d;
        logic [23:0] e;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        hs;
        logic        vs;
        logic        vde;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tv[$];
    exp_t       q[$];

    horizontal_blur_if vif();

    horizontal_blur dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .vid (vif)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] blank_exp(input logic [23:0] d);
`ifdef HBLUR_BLANK_ZERO_EN
        return 24'h0;
`else
        return d;
`endif
    endfunction

    task automatic check(input exp_t x, input string nm);
        logic [23:0] ed;
        ed = x.vde ? x.d : blank_exp(x.d);
        n_vec++;
        if (vif.o_vid_data !== ed || vif.o_vid_hsync !== x.hs ||
            vif.o_vid_vsync !== x.vs || vif.o_vid_VDE !== x.vde) begin
            n_bad++;
            $display("FAIL %s: got d=%h hs=%b vs=%b vde=%b, want d=%h hs=%b vs=%b vde=%b",
                     nm, vif.o_vid_data, vif.o_vid_hsync, vif.o_vid_vsync,
                     vif.o_vid_VDE, ed, x.hs, x.vs, x.vde);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t x;
        @(negedge clk);
        if (q.size() == 2) check(q.pop_front(), nm);
        sw               = v.sw;
        vif.i_vid_vsync  = v.vs;
        vif.i_vid_hsync  = v.hs;
        vif.i_vid_VDE    = v.vde;
        vif.i_vid_data   = v.d;
        x.d   = v.e;
        x.hs  = v.hs;
        x.vs  = v.vs;
        x.vde = v.vde;
        q.push_back(x);
    endtask

    task automatic px(input logic [3:0] s, input logic vs, input logic vde,
                      input logic [23:0] d, input logic [23:0] e, input string nm);
        vec_t v;
        v.sw = s; v.vs = vs; v.hs = 1'b0; v.vde = vde; v.d = d; v.e = e;
        step(v, nm);
    endtask

    initial begin
        exp_t z;
        rst             = 1'b1;
        sw              = 4'd0;
        vif.i_vid_data  = 24'h0;
        vif.i_vid_hsync = 1'b0;
        vif.i_vid_vsync = 1'b0;
        vif.i_vid_VDE   = 1'b0;
        z.d = 24'h0; z.hs = 1'b0; z.vs = 1'b0; z.vde = 1'b1;

        // passthrough line after reset
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0A0A0A});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h141414, 24'h141414});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h1E1E1E, 24'h1E1E1E});
        tv.push_back('{4'd0, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        // vsync with sw=3 -> blur frame
        tv.push_back('{4'd3, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0C0C0C});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'h141414, 24'h141414});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'h1E1E1E, 24'h1B1B1B});
        tv.push_back('{4'd3, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'hC8C8C8, 24'hC8C8C8});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'h640028, 24'h4B3228});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 24'h00C828, 24'h199628});
        tv.push_back('{4'd3, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        // sw=0 mid-frame: blur holds until next vsync rise
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0C0C0C});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h141414, 24'h141414});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h1E1E1E, 24'h1B1B1B});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0A0A0A});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h141414, 24'h141414});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        // sw changes in the vsync-rise cycle; long vsync has one rise only
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd3, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0C0C0C});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h141414, 24'h141414});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b1, 24'h1E1E1E, 24'h1B1B1B});
        tv.push_back('{4'd0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000});

        repeat (2) @(negedge clk);
        z.vde = 1'b0;
        check(z, "reset_state");
        rst = 1'b0;

        foreach (tv[i]) step(tv[i], $sformatf("vec%0d", i));

        // mid-line reset in blur mode clears outputs at once
        px(4'd0, 1'b0, 1'b1, 24'h0A0A0A, 24'h0C0C0C, "pre_rst0");
        px(4'd0, 1'b0, 1'b1, 24'h141414, 24'h141414, "pre_rst1");
        px(4'd0, 1'b0, 1'b1, 24'h1E1E1E, 24'h1E1E1E, "pre_rst2");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(z, "rst_async");
        q.delete();
        vif.i_vid_data = 24'h0;
        vif.i_vid_VDE  = 1'b0;
        @(negedge clk);
        check(z, "rst_held");
        rst = 1'b0;

        // sw=3 without vsync rise: still passthrough
        px(4'd3, 1'b0, 1'b1, 24'h0A0A0A, 24'h0A0A0A, "post_rst_pass0");
        px(4'd3, 1'b0, 1'b1, 24'h141414, 24'h141414, "post_rst_pass1");
        px(4'd3, 1'b0, 1'b1, 24'h1E1E1E, 24'h1E1E1E, "post_rst_pass2");
        px(4'd3, 1'b0, 1'b0, 24'h000000, 24'h000000, "post_rst_pass3");
        px(4'd3, 1'b1, 1'b0, 24'h000000, 24'h000000, "post_rst_vs");
        px(4'd3, 1'b0, 1'b0, 24'h000000, 24'h000000, "post_rst_gap");
        px(4'd3, 1'b0, 1'b1, 24'h0A0A0A, 24'h0C0C0C, "post_rst_blur0");
        px(4'd3, 1'b0, 1'b1, 24'h141414, 24'h141414, "post_rst_blur1");
        px(4'd3, 1'b0, 1'b1, 24'h1E1E1E, 24'h1B1B1B, "post_rst_blur2");
        px(4'd3, 1'b0, 1'b0, 24'h000000, 24'h000000, "drain0");
        px(4'd3, 1'b0, 1'b0, 24'h000000, 24'h000000, "drain1");
        px(4'd3, 1'b0, 1'b0, 24'h000000, 24'h000000, "drain2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
